// File: rtl/shifter_arbiter_pkg.sv
// Shared widths, one-hot shift-op bit positions and small helpers for the
// shifter arbiter and its datapath.
package shift_pkg;

    localparam int XLEN = 64;
    localparam int OPW  = 9;
    localparam int TAGW = 4;

    localparam int SHOP_SLL   = 0;
    localparam int SHOP_SRL   = 1;
    localparam int SHOP_SRA   = 2;
    localparam int SHOP_SLLW  = 3;
    localparam int SHOP_SRLW  = 4;
    localparam int SHOP_SRAW  = 5;
    localparam int SHOP_SLL_D = 6;
    localparam int SHOP_SRL_D = 7;
    localparam int SHOP_SRA_D = 8;

    function automatic logic is_onehot(input logic [OPW-1:0] op);
        return (op != '0) && ((op & (op - OPW'(1))) == '0);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/shifter_arbiter_if.sv
// Two issue requesters and one response consumer around the shared shifter.
// slave is the arbiter side, master is the requester/consumer side.
interface shifter_arbiter_if;
    import shift_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_op;
    logic [XLEN-1:0] req0_src1;
    logic [XLEN-1:0] req0_src2;
    logic [TAGW-1:0] req0_tag;

    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_op;
    logic [XLEN-1:0] req1_src1;
    logic [XLEN-1:0] req1_src2;
    logic [TAGW-1:0] req1_tag;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic [TAGW-1:0] resp_tag;
    logic            resp_src;
    logic            resp_err;

    modport slave (
        input  req0_valid, req0_op, req0_src1, req0_src2, req0_tag,
        input  req1_valid, req1_op, req1_src1, req1_src2, req1_tag,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_result, resp_tag, resp_src, resp_err
    );

    modport master (
        output req0_valid, req0_op, req0_src1, req0_src2, req0_tag,
        output req1_valid, req1_op, req1_src1, req1_src2, req1_tag,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_result, resp_tag, resp_src, resp_err
    );

endinterface

// File: rtl/shifter_arbiter_shifter.sv
// Combinational shifter: one-hot op select; word ops work on src1[31:0] and
// sign-extend the 32-bit result. An all-zero op yields zero.
module shifter
    import shift_pkg::*;
(
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result
);

    logic [4:0]      amt_w;
    logic [5:0]      amt_d;
    logic [31:0]     word;
    logic [31:0]     sllw_r;
    logic [31:0]     srlw_r;
    logic [31:0]     sraw_r;
    logic [XLEN-1:0] sra_r;
    logic [XLEN-1:0] sra_d_r;
    logic            unused_src2_hi;

    assign amt_w   = src2[4:0];
    assign amt_d   = src2[5:0];
    assign word    = src1[31:0];
    assign sllw_r  = word << amt_w;
    assign srlw_r  = word >> amt_w;
    assign sraw_r  = $signed(word) >>> amt_w;
    assign sra_r   = $signed(src1) >>> amt_w;
    assign sra_d_r = $signed(src1) >>> amt_d;
    assign unused_src2_hi = ^src2[XLEN-1:6];

    always_comb begin
        result = '0;
        if (op[SHOP_SLL])   result = result | (src1 << amt_w);
        if (op[SHOP_SRL])   result = result | (src1 >> amt_w);
        if (op[SHOP_SRA])   result = result | sra_r;
        if (op[SHOP_SLLW])  result = result | sext32(sllw_r);
        if (op[SHOP_SRLW])  result = result | sext32(srlw_r);
        if (op[SHOP_SRAW])  result = result | sext32(sraw_r);
        if (op[SHOP_SLL_D]) result = result | (src1 << amt_d);
        if (op[SHOP_SRL_D]) result = result | (src1 >> amt_d);
        if (op[SHOP_SRA_D]) result = result | sra_d_r;
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, with a
// one-entry registered response stage (1-cycle latency, 1 op/cycle).
module shifter_arbiter
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    shifter_arbiter_if.slave bus
);

    logic            last_grant;
    logic            grant;
    logic            grant_valid;
    logic            can_accept;
    logic            accept;
    logic            op_legal;
    logic [OPW-1:0]  sel_op;
    logic [OPW-1:0]  sh_op;
    logic [XLEN-1:0] sel_src1;
    logic [XLEN-1:0] sel_src2;
    logic [TAGW-1:0] sel_tag;
    logic [XLEN-1:0] sh_result;

    logic            resp_valid_q;
    logic [XLEN-1:0] resp_result_q;
    logic [TAGW-1:0] resp_tag_q;
    logic            resp_src_q;
    logic            resp_err_q;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        grant_valid = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
        else                                  grant = bus.req1_valid;
    end

    assign can_accept = !rst && !flush && (!resp_valid_q || bus.resp_ready);
    assign accept     = can_accept && grant_valid;

    assign bus.req0_ready = can_accept && grant_valid && !grant;
    assign bus.req1_ready = can_accept && grant_valid &&  grant;

    always_comb begin
        sel_op   = grant ? bus.req1_op   : bus.req0_op;
        sel_src1 = grant ? bus.req1_src1 : bus.req0_src1;
        sel_src2 = grant ? bus.req1_src2 : bus.req0_src2;
        sel_tag  = grant ? bus.req1_tag  : bus.req0_tag;
        op_legal = is_onehot(sel_op);
        sh_op    = op_legal ? sel_op : '0;
    end

    shifter u_shifter (
        .op     (sh_op),
        .src1   (sel_src1),
        .src2   (sel_src2),
        .result (sh_result)
    );

    // Drain and flush only clear the valid bit; payload fields keep their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_tag_q    <= '0;
            resp_src_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            last_grant    <= 1'b1;
        end else if (accept) begin
            resp_valid_q  <= 1'b1;
            resp_result_q <= sh_result;
            resp_tag_q    <= sel_tag;
            resp_src_q    <= grant;
            resp_err_q    <= !op_legal;
            last_grant    <= grant;
        end else if (flush || bus.resp_ready) begin
            resp_valid_q  <= 1'b0;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_tag    = resp_tag_q;
    assign bus.resp_src    = resp_src_q;
    assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: a scoreboard model predicts each
// accepted op's response; scenario tasks compare DUT outputs against it.
module tb_shifter_arbiter;
   import shift_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [TAGW-1:0] tag;
      logic            src;
      logic            err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   shifter_arbiter_if bus();

   shifter_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic m_valid = 1'b0;
   logic m_last  = 1'b1;
   logic m_acc;
   logic m_g;
   logic e_can, e_gv, e_g;

   function automatic logic [XLEN-1:0] ref_shift(input logic [OPW-1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic [31:0]            w;
      logic signed [31:0]     sw;
      int                     s5;
      int                     s6;
      sa = a;
      w  = a[31:0];
      sw = a[31:0];
      s5 = int'(b[4:0]);
      s6 = int'(b[5:0]);
      if ($countones(op) != 1) return '0;
      if (op[0]) return a << s5;
      if (op[1]) return a >> s5;
      if (op[2]) return sa >>> s5;
      if (op[3]) begin w = w << s5; return {{32{w[31]}}, w}; end
      if (op[4]) begin w = w >> s5; return {{32{w[31]}}, w}; end
      if (op[5]) begin sw = sw >>> s5; return {{32{sw[31]}}, sw}; end
      if (op[6]) return a << s6;
      if (op[7]) return a >> s6;
      return sa >>> s6;
   endfunction

   function automatic exp_t resp_now();
      return {bus.resp_result, bus.resp_tag, bus.resp_src, bus.resp_err};
   endfunction

   always_comb begin
      e_can = !rst && !flush && (!m_valid || bus.resp_ready);
      e_gv  = bus.req0_valid || bus.req1_valid;
      e_g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
   end

   // Scoreboard: the response entry is retired on drain/flush, and a new
   // prediction is pushed whenever the bench's own arbitration model accepts.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0;
         m_last  = 1'b1;
         sb.delete();
      end else begin
         m_acc = e_can && e_gv;
         m_g   = e_g;
         if (m_valid && (bus.resp_ready || flush)) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_valid = 1'b0;
         end
         if (m_acc) begin
            if (m_g)
               sb.push_back(exp_t'{ref_shift(bus.req1_op, bus.req1_src1, bus.req1_src2),
                                   bus.req1_tag, 1'b1, $countones(bus.req1_op) != 1});
            else
               sb.push_back(exp_t'{ref_shift(bus.req0_op, bus.req0_src1, bus.req0_src2),
                                   bus.req0_tag, 1'b0, $countones(bus.req0_op) != 1});
            m_last  = m_g;
            m_valid = 1'b1;
         end
      end
   end

   task automatic drive_req(input int n, input logic v, input logic [OPW-1:0] op,
                            input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                            input logic [TAGW-1:0] tag);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_src1 = s1;
         bus.req0_src2 = s2; bus.req0_tag = tag;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_src1 = s1;
         bus.req1_src2 = s2; bus.req1_tag = tag;
      end
   endtask

   task automatic idle_reqs();
      drive_req(0, 1'b0, '0, '0, '0, '0);
      drive_req(1, 1'b0, '0, '0, '0, '0);
   endtask

   function automatic logic [OPW-1:0] rand_op();
      logic [OPW-1:0] one;
      one = 1;
      return one << $urandom_range(0, OPW - 1);
   endfunction

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; bus.resp_ready = 1'b0;
      drive_req(0, 1'b1, 9'h001, 64'd1, 64'd1, 4'd1);
      drive_req(1, 1'b1, 9'h001, 64'd1, 64'd1, 4'd2);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if ({bus.resp_valid, resp_now()} !== '0) begin
         errors++;
         $display("FAIL reset_resp: got v=%b %h expected all zero", bus.resp_valid, resp_now());
      end
      idle_reqs();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid: got %b expected 0", bus.resp_valid);
      end
   endtask

   task automatic test_contention();
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_req(0, 1'b1, rand_op(), {$urandom, $urandom}, 64'($urandom), 4'(i));
         drive_req(1, 1'b1, rand_op(), {$urandom, $urandom}, 64'($urandom), 4'(i + 8));
         #1;
         checks++;
         if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b%b expected %b%b", i,
                     bus.req0_ready, bus.req1_ready, (i % 2 == 0), (i % 2 == 1));
         end
         @(negedge clk);
         checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_src !== 1'(i % 2)) begin
            errors++;
            $display("FAIL rr_src[%0d]: got v=%b src=%b expected v=1 src=%0d", i,
                     bus.resp_valid, bus.resp_src, i % 2);
         end
         checks++;
         if (sb.size() == 0 || resp_now() !== sb[0]) begin
            errors++;
            $display("FAIL rr_data[%0d]: got %h expected %h", i, resp_now(),
                     (sb.size() > 0) ? sb[0] : exp_t'('x));
         end
      end
      idle_reqs();
      @(negedge clk);
   endtask

   task automatic test_single();
      bus.resp_ready = 1'b1;
      drive_req(0, 1'b1, 9'h001, 64'd1, 64'h23, 4'd5);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_ready: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      idle_reqs();
      checks++;
      if ({bus.resp_valid, resp_now()} !== {1'b1, 64'd8, 4'd5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_resp: got v=%b %h expected v=1 result=8 tag=5", bus.resp_valid, resp_now());
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_result !== 64'd8 || bus.resp_tag !== 4'd5) begin
         errors++;
         $display("FAIL drain_hold: got v=%b r=%h t=%h expected v=0 r=8 t=5",
                  bus.resp_valid, bus.resp_result, bus.resp_tag);
      end
   endtask

   task automatic test_backpressure();
      exp_t held;
      bus.resp_ready = 1'b0;
      drive_req(0, 1'b1, rand_op(), {$urandom, $urandom}, 64'($urandom), 4'd3);
      drive_req(1, 1'b1, rand_op(), {$urandom, $urandom}, 64'($urandom), 4'd4);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_first: got %b%b expected 01", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      held = resp_now();
      checks++;
      if (sb.size() == 0 || held !== sb[0] || bus.resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_entry: got %h expected %h", held, (sb.size() > 0) ? sb[0] : exp_t'('x));
      end
      for (int i = 0; i < 3; i++) begin
         drive_req(0, 1'b1, rand_op(), {$urandom, $urandom}, 64'($urandom), 4'd6);
         #1;
         checks++;
         if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready[%0d]: got %b%b expected 00", i, bus.req0_ready, bus.req1_ready);
         end
         @(negedge clk);
         checks++;
         if (resp_now() !== held || bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got %h expected %h", i, resp_now(), held);
         end
      end
      bus.resp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      checks++;
      if (sb.size() == 0 || resp_now() !== sb[0] || bus.resp_src !== 1'b0 || bus.resp_tag !== 4'd6) begin
         errors++;
         $display("FAIL bp_next: got %h expected %h", resp_now(), (sb.size() > 0) ? sb[0] : exp_t'('x));
      end
      idle_reqs();
      @(negedge clk);
   endtask

   task automatic test_word_and_illegal();
      logic [OPW-1:0]  t_op  [10] = '{9'h020, 9'h010, 9'h008, 9'h001, 9'h040,
                                      9'h100, 9'h004, 9'h003, 9'h000, 9'h080};
      logic [XLEN-1:0] t_s1  [10] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'd1, 64'd1,
                                      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h1234, 64'h1234,
                                      64'h8000_0000_0000_0000};
      logic [XLEN-1:0] t_s2  [10] = '{64'd4, 64'd4, 64'd31, 64'h3F, 64'h3F, 64'd63, 64'h24, 64'd1, 64'd1, 64'h3F};
      logic [XLEN-1:0] t_exp [10] = '{64'hFFFF_FFFF_F800_0000, 64'h0000_0000_0800_0000, 64'hFFFF_FFFF_8000_0000,
                                      64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                      64'hF800_0000_0000_0000, 64'd0, 64'd0, 64'd1};
      logic            t_err [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_req(1, 1'b1, t_op[i], t_s1[i], t_s2[i], 4'(i));
         #1;
         checks++;
         if (bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_ready[%0d]: got %b expected 1", i, bus.req1_ready);
         end
         @(negedge clk);
         checks++;
         if (bus.resp_result !== t_exp[i] || bus.resp_err !== t_err[i] || bus.resp_src !== 1'b1) begin
            errors++;
            $display("FAIL op_result[%0d]: got %h err=%b expected %h err=%b", i,
                     bus.resp_result, bus.resp_err, t_exp[i], t_err[i]);
         end
         checks++;
         if (sb.size() == 0 || resp_now() !== sb[0]) begin
            errors++;
            $display("FAIL op_model[%0d]: got %h expected %h", i, resp_now(),
                     (sb.size() > 0) ? sb[0] : exp_t'('x));
         end
      end
      idle_reqs();
      @(negedge clk);
   endtask

   task automatic test_flush();
      bus.resp_ready = 1'b0;
      drive_req(0, 1'b1, 9'h001, 64'd3, 64'd2, 4'd9);
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_result !== 64'd12) begin
         errors++;
         $display("FAIL flush_setup: got v=%b r=%h expected v=1 r=c", bus.resp_valid, bus.resp_result);
      end
      drive_req(1, 1'b1, 9'h002, 64'd16, 64'd2, 4'd10);
      flush = 1'b1;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_kill: got %b expected 0", bus.resp_valid);
      end
      bus.resp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_grant_kept: got %b%b expected 01", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      checks++;
      if (sb.size() == 0 || resp_now() !== sb[0] || bus.resp_result !== 64'd4) begin
         errors++;
         $display("FAIL flush_next: got %h expected %h", resp_now(), (sb.size() > 0) ? sb[0] : exp_t'('x));
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      idle_reqs();
      checks++;
      if (bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drain: got %b expected 0", bus.resp_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_tag !== 4'd10) begin
         errors++;
         $display("FAIL flush_idle: got v=%b tag=%h expected v=0 tag=a", bus.resp_valid, bus.resp_tag);
      end
   endtask

   task automatic test_reset_midop();
      bus.resp_ready = 1'b0;
      drive_req(0, 1'b1, 9'h040, 64'd1, 64'd40, 4'd7);
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_setup: got %b expected 1", bus.resp_valid);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({bus.resp_valid, resp_now()} !== '0 || bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: got v=%b %h rdy=%b expected all zero",
                  bus.resp_valid, resp_now(), bus.req0_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_req(0, 1'b1, 9'h001, 64'd1, 64'd0, 4'd1);
      drive_req(1, 1'b1, 9'h001, 64'd1, 64'd0, 4'd2);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_grant: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      idle_reqs();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.resp_ready = 1'b0;
      idle_reqs();
      test_reset();
      test_contention();
      test_single();
      test_backpressure();
      test_word_and_illegal();
      test_flush();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
Shares the single combinational `shifter` datapath between two issue requesters (req0: main integer pipe, req1: secondary/microcode path) using valid/ready handshakes.
- Arbitration is round-robin, and the winning request is sent through the shifter.
- The result is captured in a one-entry registered response stage.
- Sits between issue/dispatch and writeback; provides 1-cycle latency and 1 op/cycle throughput when the response consumer never stalls.

Parameters:
XLEN, 64, operand/result width
OPW, 9, one-hot shift-op width (bit order: sll, srl, sra, sllw, srlw, sraw, SLL, SRL, SRA)
TAGW, 4, opaque requester tag width echoed with result

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of response entry and blocks acceptance this cycle
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  OPW  one-hot shift op
req0_src1  in  XLEN  value to shift
req0_src2  in  XLEN  shift amount source (low bits used per op)
req0_tag  in  TAGW  tag
req1_valid/req1_ready/req1_op/req1_src1/req1_src2/req1_tag  same as req0, for requester 1
resp_valid  out  1  response entry holds a result
resp_ready  in  1  consumer takes response
resp_result  out  XLEN  shifter result
resp_tag  out  TAGW  tag of accepted request
resp_src  out  1  0 = from req0, 1 = from req1
resp_err  out  1  op was not exactly one-hot

Behaviour:
- Reset (async, rst=1):
  - resp_valid=0, resp_result=0, resp_tag=0, resp_src=0, resp_err=0.
  - last_grant=1, so req0 wins the first contention.
  - req*_ready=0 while rst is high.
- can_accept = !flush && (!resp_valid || resp_ready). This is combinational, so a drain and an accept can happen in the same cycle.
- Grant selection (combinational):
  - Only one requester valid: that one wins.
  - Both valid: the one != last_grant wins.
  - Neither valid: no grant.
- reqN_ready = can_accept && grant==N. At most one ready is high per cycle. The ready signals depend on valids but a requester must not wait for ready before asserting valid.
- Handshake: on a cycle with reqN_valid && reqN_ready:
  - The winning op, src1 and src2 drive the shifter.
  - On the next edge: resp_result <= shifter output, resp_tag, resp_src=N, resp_err, resp_valid=1, last_grant=N.
  - last_grant changes only on an accepted handshake.
- Illegal op: op not exactly one-hot (zero or multiple bits set).
  - The op is still accepted; the shifter is driven with op=0, so result=0.
  - resp_err=1.
- Shift semantics are those of the shared `shifter`:
  - sll/srl/sra use src2[4:0].
  - SLL/SRL/SRA use src2[5:0].
  - *w ops operate on src1[31:0], use src2[4:0], and sign-extend bit 31 of the 32-bit result.
- Drain: resp_valid && resp_ready with no new accept → resp_valid=0 next edge; the other resp fields hold their old values.
- Backpressure: resp_valid && !resp_ready → all resp_* outputs stable, both readys low.
- Flush:
  - flush=1 → resp_valid=0 next edge regardless of resp_ready.
  - No accept that cycle; last_grant unchanged.
  - Flush and a drain in the same cycle: the entry is dropped once; there is no double effect.
- rst asserted mid-operation: resp_valid drops immediately (async); any in-flight accept is lost.

Decomposition:
- Shared package (shift_pkg): XLEN, OPW, TAGW, and the op bit-index constants SHOP_SLL=0 … SHOP_SRA_D=8.
- One sub-module: instantiate the existing `shifter` unchanged as the datapath.
- Arbiter, one-hot check and response register are written inline in shifter_arbiter.

Test Plan:
- Reset/idle: rst=1 pulsed mid-cycle with resp_valid=1 → resp_valid=0 immediately; all resp_* =0 after reset.
- Single request: req0 op=0x001 (sll), src1=1, src2=0x23, tag=5 → req0_ready=1 same cycle; next cycle resp_valid=1, resp_result=8, resp_tag=5, resp_src=0, resp_err=0.
- Contention: both valid every cycle, resp_ready=1 → accepts alternate req0, req1, req0, req1…, one resp per cycle, resp_src toggles starting at 0.
- Backpressure:
  - Stall: resp_ready=0 for 3 cycles with both valid → readys low, resp_result held.
  - Release: raise resp_ready → drain and a new accept occur in the same cycle.
- Word ops and illegal op:
  - req1 op=0x020 (sraw), src1=0x0000_0000_8000_0000, src2=4 → resp_result=0xFFFF_FFFF_F800_0000.
  - op=0x003 → resp_result=0, resp_err=1.
- Flush: resp_valid=1, resp_ready=0, req0_valid=1, flush=1 → req0_ready=0; next cycle resp_valid=0, last_grant unchanged.
